// File: rtl/usbh_frame_sched.sv
// Full-speed USB host frame scheduler: 1 ms frame timer, SOF issue, round-robin SIE sharing.
// Latency: request seen in IDLE -> grant + sie_start two cycles later; SOF one cycle after wrap/enable.
// Backpressure: one SIE operation at a time; requesters hold req until done, SIE paced by sie_done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 = bus running (SOFs and grants), 0 = idle/suspended
//   req/req_addr/req_endp/req_pid   per-requester level request and token fields (packed per index)
//   grant, done         one-hot ownership, one-cycle completion pulse to the owner
//   sie_start/sie_sof/sie_pid/sie_addr/sie_endp   token command to the SIE engine
//   sie_done            one-cycle completion pulse from the SIE engine
//   frame_num           11-bit number carried by the most recent/next SOF
module usbh_frame_sched #(
    parameter int N_REQ       = 2,
    parameter int FRAME_TICKS = 25000,
    parameter int EOF_GUARD   = 1500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [4*N_REQ-1:0]   req_endp,
    input  logic [2*N_REQ-1:0]   req_pid,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 sie_start,
    output logic                 sie_sof,
    output logic [1:0]           sie_pid,
    output logic [6:0]           sie_addr,
    output logic [3:0]           sie_endp,
    input  logic                 sie_done,
    output logic [10:0]          frame_num
);

    localparam int CW = $clog2(FRAME_TICKS);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_SOF_W,
        S_ARB,
        S_XFER
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sof_pend_q, sof_pend_d;
    logic             en_q, en_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [10:0]      frame_num_q, frame_num_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             sie_start_q, sie_start_d;
    logic             sie_sof_q, sie_sof_d;
    logic [1:0]       sie_pid_q, sie_pid_d;
    logic [6:0]       sie_addr_q, sie_addr_d;
    logic [3:0]       sie_endp_q, sie_endp_d;

    logic             wrap;
    logic             guard;
    logic             en_rise;
    logic             sof_clr;

    // Round-robin scan results and the selected requester's token fields
    logic             lo_found, hi_found, arb_found;
    logic [IW-1:0]    lo_idx, hi_idx, arb_idx;
    logic [6:0]       sel_addr;
    logic [3:0]       sel_endp;
    logic [1:0]       sel_pid_raw, sel_pid;
    logic [N_REQ-1:0] sel_onehot, owner_onehot;

    assign wrap    = enable && (count_q == CNT_LAST);
    assign guard   = (int'(count_q) >= FRAME_TICKS - EOF_GUARD);
    assign en_rise = enable && !en_q;

    // Frame counter and enable edge tracking
    always_comb begin
        en_d = enable;
        if (!enable || count_q == CNT_LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // A wrap beats a same-cycle clear so a back-to-back wrap is never lost;
    // a clear beats the enable-rise set because that rise is what is being served.
    always_comb begin
        if (!enable) begin
            sof_pend_d = 1'b0;
        end else if (wrap) begin
            sof_pend_d = 1'b1;
        end else if (sof_clr) begin
            sof_pend_d = 1'b0;
        end else if (en_rise) begin
            sof_pend_d = 1'b1;
        end else begin
            sof_pend_d = sof_pend_q;
        end
    end

    // Scan downward so the last hit is the lowest index; hi_* keeps the lowest
    // index at or above the pointer, lo_* the lowest overall (the wrap-around case).
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(j);
                if (IW'(j) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(j);
                end
            end
        end
        arb_found = lo_found;
        arb_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_addr     = '0;
        sel_endp     = '0;
        sel_pid_raw  = '0;
        sel_onehot   = '0;
        owner_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            sel_onehot[j]   = (IW'(j) == arb_idx);
            owner_onehot[j] = (IW'(j) == owner_q);
            if (IW'(j) == arb_idx) begin
                sel_addr    = req_addr[7*j +: 7];
                sel_endp    = req_endp[4*j +: 4];
                sel_pid_raw = req_pid[2*j +: 2];
            end
        end
        // Reserved token code goes out as OUT
        sel_pid = (sel_pid_raw == 2'd3) ? 2'd2 : sel_pid_raw;
    end

    // Scheduler FSM: command outputs are registered, so sie_start is high
    // in the SOF state and in the first XFER cycle.
    always_comb begin
        state_d     = state_q;
        sof_clr     = 1'b0;
        rr_d        = rr_q;
        owner_d     = owner_q;
        frame_num_d = frame_num_q;
        grant_d     = grant_q;
        done_d      = '0;
        sie_start_d = 1'b0;
        sie_sof_d   = sie_sof_q;
        sie_pid_d   = sie_pid_q;
        sie_addr_d  = sie_addr_q;
        sie_endp_d  = sie_endp_q;
        case (state_q)
            S_IDLE: begin
                if (enable && (sof_pend_q || en_rise)) begin
                    state_d     = S_SOF;
                    sof_clr     = 1'b1;
                    sie_start_d = 1'b1;
                    sie_sof_d   = 1'b1;
                end else if (enable && !guard && (|req)) begin
                    state_d = S_ARB;
                end
            end
            S_SOF: begin
                state_d = S_SOF_W;
            end
            S_SOF_W: begin
                if (sie_done) begin
                    frame_num_d = frame_num_q + 11'd1;
                    state_d     = S_IDLE;
                end
            end
            S_ARB: begin
                if (arb_found) begin
                    grant_d     = sel_onehot;
                    owner_d     = arb_idx;
                    sie_start_d = 1'b1;
                    sie_sof_d   = 1'b0;
                    sie_pid_d   = sel_pid;
                    sie_addr_d  = sel_addr;
                    sie_endp_d  = sel_endp;
                    state_d     = S_XFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (sie_done) begin
                    done_d  = owner_onehot;
                    grant_d = '0;
                    rr_d    = (owner_q == IDX_LAST) ? '0 : owner_q + IW'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            sof_pend_q  <= 1'b0;
            en_q        <= 1'b0;
            rr_q        <= '0;
            owner_q     <= '0;
            frame_num_q <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            sie_start_q <= 1'b0;
            sie_sof_q   <= 1'b0;
            sie_pid_q   <= '0;
            sie_addr_q  <= '0;
            sie_endp_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sof_pend_q  <= sof_pend_d;
            en_q        <= en_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            frame_num_q <= frame_num_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            sie_start_q <= sie_start_d;
            sie_sof_q   <= sie_sof_d;
            sie_pid_q   <= sie_pid_d;
            sie_addr_q  <= sie_addr_d;
            sie_endp_q  <= sie_endp_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign sie_start = sie_start_q;
    assign sie_sof   = sie_sof_q;
    assign sie_pid   = sie_pid_q;
    assign sie_addr  = sie_addr_q;
    assign sie_endp  = sie_endp_q;
    assign frame_num = frame_num_q;

endmodule

// File: tb/tb_usbh_frame_sched.sv
// Directed bench for usbh_frame_sched with a 32-cycle frame and 8-cycle end-of-frame guard.
// Count values below are frame-counter positions; an SOF start is visible while the counter reads 1.
// SIE is modelled either by an auto responder (fixed latency) or by explicit pulses from the tests.
module tb_usbh_frame_sched;

    localparam int FT = 32;
    localparam int EG = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  req;
    logic [13:0] req_addr;
    logic [7:0]  req_endp;
    logic [3:0]  req_pid;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        sie_start;
    logic        sie_sof;
    logic [1:0]  sie_pid;
    logic [6:0]  sie_addr;
    logic [3:0]  sie_endp;
    logic        sie_done;
    logic [10:0] frame_num;

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   base;
    int   lat;
    logic auto_en;
    logic auto_done;
    logic man_done;

    assign sie_done = (auto_en & auto_done) | man_done;

    usbh_frame_sched #(
        .N_REQ      (2),
        .FRAME_TICKS(FT),
        .EOF_GUARD  (EG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .req      (req),
        .req_addr (req_addr),
        .req_endp (req_endp),
        .req_pid  (req_pid),
        .grant    (grant),
        .done     (done),
        .sie_start(sie_start),
        .sie_sof  (sie_sof),
        .sie_pid  (sie_pid),
        .sie_addr (sie_addr),
        .sie_endp (sie_endp),
        .sie_done (sie_done),
        .frame_num(frame_num)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Auto SIE: sie_done high in the cycle 'lat' cycles after a visible sie_start
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            if (sie_start === 1'b1) begin
                repeat (lat) @(posedge clk);
                #1 auto_done = 1'b1;
                @(posedge clk);
                #1 auto_done = 1'b0;
            end
        end
    end

    function automatic int cur_count();
        return (cyc - base + 1) % FT;
    endfunction

    task automatic wait_start(input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (sie_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_count(input int target, input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (cur_count() == target) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (done !== 2'b00) ok = 1'b1;
        end
    endtask

    // Drive a one-cycle sie_done sampled at the edge ending the current cycle
    task automatic pulse_sie_done();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        req      = 2'b00;
        man_done = 1'b0;
        auto_en  = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Requester 0: addr 0 endp 0 SETUP; requester 1: addr 5 endp 1 IN
    task automatic load_default_fields();
        req_addr = {7'd5, 7'd0};
        req_endp = {4'd1, 4'd0};
        req_pid  = {2'd1, 2'd0};
    endtask

    task automatic start_bus(output bit ok);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_start(5, ok);
        base = cyc;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        req      = 2'b00;
        man_done = 1'b0;
        auto_en  = 1'b0;
        load_default_fields();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({grant, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_grant_done got %b exp 0000", {grant, done});
        end
        n_chk++;
        if ({sie_start, sie_sof, sie_pid, sie_addr, sie_endp} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_sie got %b exp 0", {sie_start, sie_sof, sie_pid, sie_addr, sie_endp});
        end
        n_chk++;
        if (frame_num !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_frame_num got %0d exp 0", frame_num);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++;
        if (sie_start !== 1'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_disabled got start=%b grant=%b exp 0/00", sie_start, grant);
        end
    endtask

    task automatic test_sof_period();
        bit          ok;
        int          last;
        logic [10:0] exp_fn;
        do_reset();
        lat     = 20;
        auto_en = 1'b1;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        n_chk++;
        if (sie_start !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_not_same_cycle got %b exp 0", sie_start);
        end
        @(negedge clk);
        n_chk++;
        if (sie_start !== 1'b1 || sie_sof !== 1'b1 || frame_num !== 11'd0) begin
            n_fail++;
            $display("FAIL sof_first got start=%b sof=%b fn=%0d exp 1/1/0", sie_start, sie_sof, frame_num);
        end
        last = cyc;
        for (int k = 1; k <= 2048; k++) begin
            wait_start(FT + 8, ok);
            exp_fn = 11'(k % 2048);
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL sof_timeout frame %0d got none exp start within %0d", k, FT + 8);
            end
            n_chk++;
            if (cyc - last != FT || sie_sof !== 1'b1) begin
                n_fail++;
                $display("FAIL sof_period frame %0d got %0d sof=%b exp %0d sof=1", k, cyc - last, sie_sof, FT);
            end
            n_chk++;
            if (frame_num !== exp_fn) begin
                n_fail++;
                $display("FAIL sof_frame_num got %0d exp %0d", frame_num, exp_fn);
            end
            last = cyc;
        end
    endtask

    task automatic test_round_robin();
        bit         ok;
        bit         got;
        int         tries;
        int         e;
        logic [1:0] exp_g;
        logic [6:0] exp_a;
        logic [3:0] exp_ep;
        logic [1:0] exp_p;
        do_reset();
        lat     = 4;
        auto_en = 1'b1;
        load_default_fields();
        req = 2'b11;
        @(posedge clk);
        #1 enable = 1'b1;
        for (int n = 0; n < 4; n++) begin
            got   = 1'b0;
            tries = 0;
            while (!got && tries < 6) begin
                wait_start(80, ok);
                tries++;
                if (ok && sie_sof === 1'b0) got = 1'b1;
            end
            e      = n % 2;
            exp_g  = (e == 0) ? 2'b01 : 2'b10;
            exp_a  = (e == 0) ? 7'd0 : 7'd5;
            exp_ep = (e == 0) ? 4'd0 : 4'd1;
            exp_p  = (e == 0) ? 2'd0 : 2'd1;
            n_chk++;
            if (!got) begin
                n_fail++;
                $display("FAIL rr_start_timeout xfer %0d got none exp start", n);
            end
            n_chk++;
            if (grant !== exp_g) begin
                n_fail++;
                $display("FAIL rr_grant xfer %0d got %b exp %b", n, grant, exp_g);
            end
            n_chk++;
            if (sie_addr !== exp_a || sie_endp !== exp_ep || sie_pid !== exp_p) begin
                n_fail++;
                $display("FAIL rr_token xfer %0d got a=%0d e=%0d p=%0d exp a=%0d e=%0d p=%0d",
                         n, sie_addr, sie_endp, sie_pid, exp_a, exp_ep, exp_p);
            end
            @(negedge clk);
            n_chk++;
            if (sie_start !== 1'b0 || grant !== exp_g) begin
                n_fail++;
                $display("FAIL rr_hold xfer %0d got start=%b grant=%b exp 0/%b", n, sie_start, grant, exp_g);
            end
            wait_done(20, ok);
            n_chk++;
            if (!ok || done !== exp_g) begin
                n_fail++;
                $display("FAIL rr_done xfer %0d got %b exp %b", n, done, exp_g);
            end
        end
    endtask

    task automatic test_guard();
        bit ok;
        bit bad;
        bit sof_seen;
        int t_sof;
        int n;
        do_reset();
        lat     = 4;
        auto_en = 1'b1;
        load_default_fields();
        start_bus(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL guard_first_sof got none exp start");
        end
        // Last pre-guard count: request must still be served, 2 cycles later
        wait_count(FT - EG - 1, 40, ok);
        req = 2'b01;
        @(negedge clk);
        n_chk++;
        if (grant !== 2'b00) begin
            n_fail++;
            $display("FAIL latency_early got %b exp 00", grant);
        end
        @(negedge clk);
        n_chk++;
        if (grant !== 2'b01 || sie_start !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_two got grant=%b start=%b exp 01/1", grant, sie_start);
        end
        wait_done(20, ok);
        n_chk++;
        if (!ok || done !== 2'b01) begin
            n_fail++;
            $display("FAIL guard_pre_done got %b exp 01", done);
        end
        req = 2'b00;
        // Request arriving on the first guard count waits for the next SOF
        wait_count(FT - EG, 40, ok);
        req      = 2'b10;
        bad      = 1'b0;
        sof_seen = 1'b0;
        t_sof    = 0;
        n        = 0;
        while (!sof_seen && n < 20) begin
            @(negedge clk);
            n++;
            if (grant !== 2'b00) bad = 1'b1;
            if (sie_start === 1'b1 && sie_sof === 1'b0) bad = 1'b1;
            if (sie_start === 1'b1 && sie_sof === 1'b1) begin
                sof_seen = 1'b1;
                t_sof    = cyc;
            end
        end
        n_chk++;
        if (!sof_seen || bad) begin
            n_fail++;
            $display("FAIL guard_block got sof_seen=%b early_grant=%b exp 1/0", sof_seen, bad);
        end
        n = 0;
        while (grant === 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (cyc - t_sof != 7 || grant !== 2'b10 || sie_addr !== 7'd5) begin
            n_fail++;
            $display("FAIL guard_release got delay=%0d grant=%b addr=%0d exp 7/10/5", cyc - t_sof, grant, sie_addr);
        end
        req = 2'b00;
    endtask

    task automatic test_late_sof();
        bit ok;
        bit bad;
        int t;
        do_reset();
        req_addr = {7'd5, 7'd3};
        req_endp = {4'd1, 4'd2};
        req_pid  = {2'd1, 2'd3};
        start_bus(ok);
        wait_count(5, 10, ok);
        pulse_sie_done();
        n_chk++;
        if (frame_num !== 11'd1) begin
            n_fail++;
            $display("FAIL late_fn_first got %0d exp 1", frame_num);
        end
        wait_count(20, 40, ok);
        req = 2'b01;
        wait_start(5, ok);
        n_chk++;
        if (!ok || cur_count() != 22 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL late_grant got count=%0d grant=%b exp 22/01", cur_count(), grant);
        end
        n_chk++;
        if (sie_pid !== 2'd2 || sie_addr !== 7'd3 || sie_endp !== 4'd2 || sie_sof !== 1'b0) begin
            n_fail++;
            $display("FAIL late_token got p=%0d a=%0d e=%0d sof=%b exp 2/3/2/0", sie_pid, sie_addr, sie_endp, sie_sof);
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (sie_start !== 1'b0 || grant !== 2'b01) bad = 1'b1;
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL late_no_preempt got disturbance=1 exp 0");
        end
        pulse_sie_done();
        n_chk++;
        if (done !== 2'b01 || grant !== 2'b00 || sie_start !== 1'b0) begin
            n_fail++;
            $display("FAIL late_done got done=%b grant=%b start=%b exp 01/00/0", done, grant, sie_start);
        end
        req = 2'b00;
        @(negedge clk);
        n_chk++;
        if (sie_start !== 1'b1 || sie_sof !== 1'b1 || frame_num !== 11'd1) begin
            n_fail++;
            $display("FAIL late_sof got start=%b sof=%b fn=%0d exp 1/1/1", sie_start, sie_sof, frame_num);
        end
        t = cyc;
        wait_count(14, 10, ok);
        pulse_sie_done();
        wait_start(40, ok);
        n_chk++;
        if (!ok || sie_sof !== 1'b1 || cyc - t != 21 || frame_num !== 11'd2) begin
            n_fail++;
            $display("FAIL late_next_sof got ok=%b sof=%b gap=%0d fn=%0d exp 1/1/21/2", ok, sie_sof, cyc - t, frame_num);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit bad;
        do_reset();
        load_default_fields();
        start_bus(ok);
        wait_count(5, 10, ok);
        pulse_sie_done();
        wait_count(8, 10, ok);
        req = 2'b10;
        wait_start(5, ok);
        n_chk++;
        if (!ok || grant !== 2'b10) begin
            n_fail++;
            $display("FAIL en_pre_grant got %b exp 10", grant);
        end
        enable = 1'b0;
        bad    = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (sie_start !== 1'b0 || grant !== 2'b10) bad = 1'b1;
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL en_low_xfer_hold got disturbance=1 exp 0");
        end
        pulse_sie_done();
        n_chk++;
        if (done !== 2'b10 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL en_low_done got done=%b grant=%b exp 10/00", done, grant);
        end
        req = 2'b00;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (sie_start !== 1'b0 || grant !== 2'b00) bad = 1'b1;
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL en_low_quiet got activity=1 exp 0");
        end
        enable = 1'b1;
        @(negedge clk);
        n_chk++;
        if (sie_start !== 1'b1 || sie_sof !== 1'b1 || frame_num !== 11'd1) begin
            n_fail++;
            $display("FAIL en_resume_sof got start=%b sof=%b fn=%0d exp 1/1/1", sie_start, sie_sof, frame_num);
        end
    endtask

    task automatic test_reset_mid_xfer();
        bit ok;
        bit bad;
        do_reset();
        load_default_fields();
        start_bus(ok);
        wait_count(5, 10, ok);
        pulse_sie_done();
        wait_count(8, 10, ok);
        req = 2'b01;
        wait_start(5, ok);
        n_chk++;
        if (!ok || grant !== 2'b01 || frame_num !== 11'd1) begin
            n_fail++;
            $display("FAIL rst_pre got grant=%b fn=%0d exp 01/1", grant, frame_num);
        end
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        n_chk++;
        if (grant !== 2'b00 || sie_start !== 1'b0 || frame_num !== 11'd0 || sie_sof !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async got grant=%b start=%b fn=%0d sof=%b exp 00/0/0/0", grant, sie_start, frame_num, sie_sof);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_sie_done();
        bad = 1'b0;
        repeat (5) begin
            if (done !== 2'b00 || grant !== 2'b00) bad = 1'b1;
            @(negedge clk);
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_no_done got stray done/grant=1 exp 0");
        end
        req = 2'b00;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        base     = 0;
        lat      = 4;
        rst_n    = 1'b0;
        enable   = 1'b0;
        req      = 2'b00;
        req_addr = '0;
        req_endp = '0;
        req_pid  = '0;
        man_done = 1'b0;
        auto_en  = 1'b0;
        test_reset();
        test_sof_period();
        test_round_robin();
        test_guard();
        test_late_sof();
        test_enable_drop();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
